wallet_access_ctrl: RTL and testbench

//  Downstream consumer of the access decoder's outputs (access_type, access_p2, wren, data_in).

---
 rtl/wallet_pkg.sv | 20 ++
 rtl/wallet_access_ctrl_if.sv | 27 ++
 rtl/wallet_sat_add.sv | 35 +++
 rtl/wallet_access_ctrl.sv | 110 +++++++++++
 tb/tb_wallet_access_ctrl.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/wallet_pkg.sv
// Shared constants and FSM state type for the wallet access controller.
package wallet_pkg;

   localparam logic [1:0] ACC_NET = 2'b10;
   localparam logic [1:0] ACC_KEY = 2'b01;
   localparam logic [1:0] ACC_ADD = 2'b11;
   localparam logic [1:0] ACC_ILL = 2'b00;

   localparam logic FLD_NET = 1'b0;
   localparam logic FLD_KEY = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      RD,
      WAIT,
      WR,
      RESP
   } state_t;

endpackage

// File: rtl/wallet_access_ctrl_if.sv
// Request/response channel between the access decoder side and the wallet controller.
interface wallet_access_ctrl_if #(
   parameter int DATA_W = 8
);

   logic              req_valid;
   logic              req_ready;
   logic [1:0]        access_type;
   logic              access_p2;
   logic              wren;
   logic [DATA_W-1:0] data_in;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_err;

   modport master (
      output req_valid, access_type, access_p2, wren, data_in, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_err
   );

   modport slave (
      input  req_valid, access_type, access_p2, wren, data_in, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_err
   );

endinterface

// File: rtl/wallet_sat_add.sv
// Net-money adder: unsigned balance plus signed delta.
// WALLET_SAT_EN selects clamping to [0, 2^DATA_W-1]; otherwise wrap and flag overflow.
module wallet_sat_add #(
   parameter int DATA_W = 8
) (
   input  logic [DATA_W-1:0]        base,
   input  logic signed [DATA_W-1:0] delta,
   output logic [DATA_W-1:0]        result,
   output logic                     ovf
);

   logic signed [DATA_W+1:0] wide;
   logic                     under;
   logic                     over;

   // Two guard bits: the top one is the sign (borrow), the next one is the carry.
   assign wide  = $signed({2'b00, base}) + $signed({{2{delta[DATA_W-1]}}, delta});
   assign under = wide[DATA_W+1];
   assign over  = !wide[DATA_W+1] && wide[DATA_W];

   always_comb begin
      result = wide[DATA_W-1:0];
      ovf    = 1'b0;
`ifdef WALLET_SAT_EN
      if (under) begin
         result = '0;
      end else if (over) begin
         result = '1;
      end
`else
      ovf = under | over;
`endif
   end

endmodule

// File: rtl/wallet_access_ctrl.sv
// Wallet RAM sequencer: one read, write or read-modify-write add per request.
// Build option WALLET_SAT_EN makes the add saturate instead of wrapping.
module wallet_access_ctrl
   import wallet_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic                 clock,
   input  logic                 reset,
   wallet_access_ctrl_if.slave  bus,
   output logic [ADDR_W-1:0]    ram_addr,
   output logic                 ram_wren,
   output logic [DATA_W-1:0]    ram_data,
   input  logic [DATA_W-1:0]    ram_q,
   output logic                 busy
);

   state_t                   state;
   logic                     op_add;
   logic signed [DATA_W-1:0] delta;
   logic [DATA_W-1:0]        sum;
   logic                     ovf;

   function automatic logic [ADDR_W-1:0] wallet_addr(input logic p2, input logic fld);
      return {{(ADDR_W-2){1'b0}}, p2, fld};
   endfunction

   wallet_sat_add #(.DATA_W(DATA_W)) u_add (
      .base   (ram_q),
      .delta  (delta),
      .result (sum),
      .ovf    (ovf)
   );

   assign bus.req_ready = (state == IDLE);
   assign busy          = (state != IDLE);

   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= IDLE;
         op_add        <= 1'b0;
         delta         <= '0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_data  <= '0;
         bus.rsp_err   <= 1'b0;
         ram_wren      <= 1'b0;
         ram_addr      <= '0;
         ram_data      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  op_add <= (bus.access_type == ACC_ADD) && bus.wren;
                  delta  <= bus.data_in;
                  if (bus.access_type == ACC_ILL) begin
                     bus.rsp_valid <= 1'b1;
                     bus.rsp_data  <= '0;
                     bus.rsp_err   <= 1'b1;
                     state         <= RESP;
                  end else begin
                     bus.rsp_err <= 1'b0;
                     // Only the key type addresses field 1; add always targets net money.
                     ram_addr    <= wallet_addr(bus.access_p2,
                                      (bus.access_type == ACC_KEY) ? FLD_KEY : FLD_NET);
                     if (bus.access_type == ACC_ADD || !bus.wren) begin
                        state <= RD;
                     end else begin
                        ram_wren <= 1'b1;
                        ram_data <= bus.data_in;
                        state    <= WR;
                     end
                  end
               end
            end
            RD: begin
               state <= WAIT;
            end
            WAIT: begin
               if (op_add) begin
                  ram_wren    <= 1'b1;
                  ram_data    <= sum;
                  bus.rsp_err <= ovf;
                  state       <= WR;
               end else begin
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_data  <= ram_q;
                  state         <= RESP;
               end
            end
            WR: begin
               ram_wren      <= 1'b0;
               bus.rsp_valid <= 1'b1;
               bus.rsp_data  <= ram_data;
               state         <= RESP;
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  bus.rsp_valid <= 1'b0;
                  state         <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wallet_access_ctrl.sv
// Scoreboard bench for wallet_access_ctrl with a behavioural synchronous RAM.
module tb_wallet_access_ctrl;
   import wallet_pkg::*;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 4;

`ifdef WALLET_SAT_EN
   localparam logic [7:0] T3_D = 8'hFF;
   localparam logic       T3_E = 1'b0;
   localparam logic [7:0] T4_D = 8'h00;
   localparam logic       T4_E = 1'b0;
   localparam logic [7:0] T7_D = 8'h03;
`else
   localparam logic [7:0] T3_D = 8'h10;
   localparam logic       T3_E = 1'b1;
   localparam logic [7:0] T4_D = 8'hFB;
   localparam logic       T4_E = 1'b1;
   localparam logic [7:0] T7_D = 8'hFE;
`endif

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   wallet_access_ctrl_if #(.DATA_W(DATA_W)) bus ();
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_wren;
   logic [DATA_W-1:0] ram_data;
   logic [DATA_W-1:0] ram_q;
   logic              busy;

   wallet_access_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clock    (clock),
      .reset    (reset),
      .bus      (bus),
      .ram_addr (ram_addr),
      .ram_wren (ram_wren),
      .ram_data (ram_data),
      .ram_q    (ram_q),
      .busy     (busy)
   );

   // Single-port RAM, read data one cycle after the address; pl_* is a preload backdoor.
   logic [DATA_W-1:0] mem [16];
   logic              pl_we = 1'b0;
   logic [3:0]        pl_addr = '0;
   logic [7:0]        pl_data = '0;
   always @(posedge clock) begin
      if (ram_wren) mem[ram_addr] <= ram_data;
      if (pl_we) mem[pl_addr] <= pl_data;
      ram_q <= mem[ram_addr];
   end

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      logic [7:0] data;
      logic       err;
      int         lat;
      int         hold;
      int         cap;
   } rsp_t;

   typedef struct {
      logic [3:0] addr;
      logic [7:0] data;
   } wr_t;

   rsp_t rsp_q[$];
   wr_t  wr_q[$];
   int   pass_cnt = 0;
   int   chk_cnt  = 0;
   bit   cur_act  = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic fail_now(input string name);
      chk_cnt++;
      $display("FAIL %s", name);
   endtask

   // Monitor: RAM write events and response channel, also owns rsp_ready.
   initial begin
      rsp_t             cur;
      wr_t              w;
      int               hold;
      logic [DATA_W-1:0] held;
      hold = 0;
      held = '0;
      bus.rsp_ready = 1'b1;
      forever begin
         @(negedge clock);
         if (reset) begin
            cur_act = 1'b0;
            bus.rsp_ready = 1'b1;
         end else begin
            if (ram_wren) begin
               if (wr_q.size() == 0) begin
                  fail_now($sformatf("unexpected ram write addr=0x%0h data=0x%0h", ram_addr, ram_data));
               end else begin
                  w = wr_q.pop_front();
                  check("ram_addr", ram_addr, w.addr);
                  check("ram_data", ram_data, w.data);
               end
            end
            if (bus.rsp_valid && !cur_act) begin
               if (rsp_q.size() == 0) begin
                  fail_now($sformatf("unexpected response data=0x%0h", bus.rsp_data));
               end else begin
                  cur = rsp_q.pop_front();
                  cur_act = 1'b1;
                  check("rsp latency", cyc - cur.cap + 1, cur.lat);
                  held = bus.rsp_data;
                  hold = cur.hold;
               end
            end
            if (bus.rsp_valid && cur_act) begin
               if (hold > 0) begin
                  bus.rsp_ready = 1'b0;
                  hold--;
                  check("held rsp_data", bus.rsp_data, held);
                  check("held req_ready", bus.req_ready, 0);
               end else begin
                  bus.rsp_ready = 1'b1;
                  check("rsp_data", bus.rsp_data, cur.data);
                  check("rsp_err", bus.rsp_err, cur.err);
                  cur_act = 1'b0;
               end
            end
         end
      end
   end

   task automatic preload(input logic [3:0] a, input logic [7:0] d);
      @(negedge clock);
      pl_addr = a;
      pl_data = d;
      pl_we   = 1'b1;
      @(negedge clock);
      pl_we   = 1'b0;
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (!bus.req_ready && n < 50) begin
         @(negedge clock);
         n++;
      end
      if (!bus.req_ready) fail_now("req_ready timeout");
   endtask

   task automatic issue(input logic [1:0] t, input logic p2, input logic wr, input logic [7:0] d,
                        input logic [7:0] exp_d, input logic exp_e, input int lat, input int hold,
                        input bit has_wr, input logic [3:0] wa, input logic [7:0] wd);
      rsp_t r;
      wr_t  w;
      int   n;
      @(negedge clock);
      wait_ready();
      if (has_wr) begin
         w.addr = wa;
         w.data = wd;
         wr_q.push_back(w);
      end
      bus.access_type = t;
      bus.access_p2   = p2;
      bus.wren        = wr;
      bus.data_in     = d;
      bus.req_valid   = 1'b1;
      @(posedge clock);
      #1;
      r.data = exp_d;
      r.err  = exp_e;
      r.lat  = lat;
      r.hold = hold;
      r.cap  = cyc;
      rsp_q.push_back(r);
      bus.req_valid = 1'b0;
      bus.data_in   = 8'hA5;
      n = 0;
      while ((rsp_q.size() != 0 || wr_q.size() != 0 || cur_act) && n < 60) begin
         @(posedge clock);
         n++;
      end
      if (rsp_q.size() != 0 || wr_q.size() != 0 || cur_act) begin
         fail_now("response timeout");
         rsp_q.delete();
         wr_q.delete();
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " req_ready"}, bus.req_ready, 1);
      check({tag, " rsp_valid"}, bus.rsp_valid, 0);
      check({tag, " rsp_data"}, bus.rsp_data, 0);
      check({tag, " rsp_err"}, bus.rsp_err, 0);
      check({tag, " ram_wren"}, ram_wren, 0);
      check({tag, " ram_addr"}, ram_addr, 0);
      check({tag, " ram_data"}, ram_data, 0);
      check({tag, " busy"}, busy, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.req_valid   = 1'b0;
      bus.access_type = ACC_ILL;
      bus.access_p2   = 1'b0;
      bus.wren        = 1'b0;
      bus.data_in     = '0;
      repeat (3) @(negedge clock);
      check_reset_outputs("reset");
      reset = 1'b0;

      issue(ACC_KEY, 1'b1, 1'b1, 8'h5A, 8'h5A, 1'b0, 2, 0, 1'b1, 4'd3, 8'h5A);
      preload(4'd0, 8'h40);
      issue(ACC_NET, 1'b0, 1'b0, 8'h00, 8'h40, 1'b0, 3, 0, 1'b0, 4'd0, 8'h00);
      preload(4'd2, 8'hF0);
      issue(ACC_ADD, 1'b1, 1'b1, 8'h20, T3_D, T3_E, 4, 0, 1'b1, 4'd2, T3_D);
      preload(4'd0, 8'h05);
      issue(ACC_ADD, 1'b0, 1'b1, 8'hF6, T4_D, T4_E, 4, 0, 1'b1, 4'd0, T4_D);
      issue(ACC_ILL, 1'b0, 1'b1, 8'h77, 8'h00, 1'b1, 1, 0, 1'b0, 4'd0, 8'h00);
      issue(ACC_KEY, 1'b1, 1'b0, 8'h00, 8'h5A, 1'b0, 3, 5, 1'b0, 4'd0, 8'h00);
      issue(ACC_ADD, 1'b0, 1'b1, 8'h03, T7_D, 1'b0, 4, 0, 1'b1, 4'd0, T7_D);
      issue(ACC_NET, 1'b1, 1'b1, 8'hC3, 8'hC3, 1'b0, 2, 0, 1'b1, 4'd2, 8'hC3);

      // Abort an add while it waits for RAM data; its write must never happen.
      @(negedge clock);
      wait_ready();
      bus.access_type = ACC_ADD;
      bus.access_p2   = 1'b1;
      bus.wren        = 1'b1;
      bus.data_in     = 8'h01;
      bus.req_valid   = 1'b1;
      @(posedge clock);
      #1;
      bus.req_valid = 1'b0;
      @(negedge clock);
      @(negedge clock);
      check("busy before abort", busy, 1);
      reset = 1'b1;
      @(posedge clock);
      #1;
      check_reset_outputs("abort");
      @(negedge clock);
      reset = 1'b0;
      repeat (3) @(negedge clock);
      check("abort mem unchanged", mem[2], 8'hC3);
      issue(ACC_NET, 1'b1, 1'b0, 8'h00, 8'hC3, 1'b0, 3, 0, 1'b0, 4'd0, 8'h00);

      repeat (3) @(negedge clock);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
